ref_period_counter: RTL and testbench

- Producer side of the save/clear counter handshake in the ADPLL.
- Counts fpga_clk cycles between rising edges of an asynchronous reference input (ref or DCO-derived).
- On each edge it publishes the count, pulses a trigger, and holds the value until the downstream saver acknowledges with its cleared flag.
- Feeds the saver's trigger/counter_val inputs and consumes its cleared output.

---
 rtl/adpll_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/ref_period_counter.sv | 96 +++++++++
 tb/tb_ref_period_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL types: period-counter state encoding and default counter width.
package adpll_pkg;

    localparam int DEFAULT_WIDTH = 20;

    typedef enum logic [1:0] {
        S_ALIGN,
        S_COUNT,
        S_WAIT_ACK
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_p1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q   <= '0;
            level_p1 <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            level_p1 <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~level_p1;

endmodule

// File: rtl/ref_period_counter.sv
// Measures reference periods in fpga_clk cycles and hands each result to the saver
// through a trigger / cleared handshake.
module ref_period_counter
    import adpll_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             fpga_clk_i,
    input  logic             reset_n_i,
    input  logic             ref_i,
    input  logic             counter_cleared_i,
    output logic             trigger_o,
    output logic [WIDTH-1:0] counter_val_o,
    output logic             busy_o,
    output logic             missed_ack_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    function automatic logic at_max(input logic [WIDTH-1:0] v);
        return v == CNT_MAX;
    endfunction

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return at_max(v) ? CNT_MAX : v + 1'b1;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             ref_rise;
    logic             ref_level_unused;
    logic             publish;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_sync (
        .clk_i    (fpga_clk_i),
        .reset_n_i(reset_n_i),
        .async_i  (ref_i),
        .level_o  (ref_level_unused),
        .rise_o   (ref_rise)
    );

    // The first edge after reset only aligns the counter; every later edge publishes.
    assign publish = ref_rise && (state_q != S_ALIGN);

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_ALIGN;
            cnt_q         <= '0;
            counter_val_o <= '0;
            trigger_o     <= 1'b0;
            busy_o        <= 1'b0;
            missed_ack_o  <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            trigger_o <= 1'b0;

            if (publish) begin
                counter_val_o <= sat_inc(cnt_q);
                trigger_o     <= 1'b1;
                busy_o        <= 1'b1;
                cnt_q         <= '0;
                if (at_max(cnt_q)) overflow_o <= 1'b1;
            end else if (state_q != S_ALIGN) begin
                cnt_q <= sat_inc(cnt_q);
                if (at_max(cnt_q)) overflow_o <= 1'b1;
            end

            case (state_q)
                S_ALIGN: begin
                    if (ref_rise) begin
                        cnt_q   <= '0;
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (ref_rise) state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // A coincident acknowledge retires the old value; the new publish keeps busy set.
                    if (ref_rise) begin
                        if (!counter_cleared_i) missed_ack_o <= 1'b1;
                    end else if (counter_cleared_i) begin
                        busy_o  <= 1'b0;
                        state_q <= S_COUNT;
                    end
                end
                default: state_q <= S_ALIGN;
            endcase
        end
    end

endmodule

// File: tb/tb_ref_period_counter.sv
// Directed bench for ref_period_counter: a default-width instance and a 4-bit instance
// for saturation, with published values checked against a scoreboard queue.
module tb_ref_period_counter;

    logic        clk;
    logic        rst_n;
    logic        ref_a, ack_a, trig_a, busy_a, missed_a, ovf_a;
    logic [19:0] val_a;
    logic        ref_b, ack_b, trig_b, busy_b, missed_b, ovf_b;
    logic [3:0]  val_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_a[$];
    int exp_b[$];

    ref_period_counter dut (
        .fpga_clk_i       (clk),
        .reset_n_i        (rst_n),
        .ref_i            (ref_a),
        .counter_cleared_i(ack_a),
        .trigger_o        (trig_a),
        .counter_val_o    (val_a),
        .busy_o           (busy_a),
        .missed_ack_o     (missed_a),
        .overflow_o       (ovf_a)
    );

    ref_period_counter #(.WIDTH(4), .SYNC_STAGES(2)) dut_w4 (
        .fpga_clk_i       (clk),
        .reset_n_i        (rst_n),
        .ref_i            (ref_b),
        .counter_cleared_i(ack_b),
        .trigger_o        (trig_b),
        .counter_val_o    (val_b),
        .busy_o           (busy_b),
        .missed_ack_o     (missed_b),
        .overflow_o       (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic get_trig(input bit sel);
        return sel ? trig_b : trig_a;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive_ref(input bit sel, input logic v);
        if (sel) ref_b = v;
        else     ref_a = v;
    endtask

    task automatic drive_ack(input bit sel, input logic v);
        if (sel) ack_b = v;
        else     ack_a = v;
    endtask

    // One reference period of p cycles starting with a rising edge now.
    // exp >= 0: the edge must publish exp. a >= 0: acknowledge a cycles after the trigger.
    // coinc: raise the acknowledge so it lands on the publishing clock edge.
    task automatic run_period(input bit sel, input int p, input int a, input int exp, input bit coinc);
        int busy_cnt = 0;
        for (int i = 0; i < p; i++) begin
            if (i == 0) begin
                if (exp >= 0) begin
                    if (sel) exp_b.push_back(exp);
                    else     exp_a.push_back(exp);
                end
                drive_ref(sel, 1'b1);
            end
            if (i == 2) begin
                if (coinc) drive_ack(sel, 1'b1);
                if (exp >= 0) check("trig_early", get_trig(sel), 1'b0);
            end
            if (i == 3) begin
                if (coinc) drive_ack(sel, 1'b0);
                if (exp >= 0) begin
                    check("trig_latency", get_trig(sel), 1'b1);
                    check("busy_on_publish", get_busy(sel), 1'b1);
                end
            end
            if (a >= 0 && i == 3 + a) drive_ack(sel, 1'b1);
            if (a >= 0 && i == 4 + a) drive_ack(sel, 1'b0);
            if (i == 8) drive_ref(sel, 1'b0);
            if (i >= 3 && get_busy(sel)) busy_cnt++;
            tick(1);
        end
        if (a >= 0) check("busy_length", busy_cnt, a + 1);
    endtask

    always @(negedge clk) begin
        if (trig_a === 1'b1) begin
            if (exp_a.size() == 0) check("trig_a_unexpected", trig_a, 1'b0);
            else                   check("val_a", val_a, exp_a.pop_front());
        end
        if (trig_b === 1'b1) begin
            if (exp_b.size() == 0) check("trig_b_unexpected", trig_b, 1'b0);
            else                   check("val_b", val_b, exp_b.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        ref_a = 1'b0; ack_a = 1'b0;
        ref_b = 1'b0; ack_b = 1'b0;

        // Reset held with ref toggling
        for (int i = 0; i < 10; i++) begin
            ref_a = i[0];
            ref_b = i[0];
            tick(1);
        end
        check("rst_trig", trig_a, 1'b0);
        check("rst_val", val_a, 20'h0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_missed", missed_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_val_w4", val_b, 4'h0);
        ref_a = 1'b0;
        ref_b = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Alignment edge is not published, then steady 40-cycle periods
        run_period(0, 40, -1, -1, 0);
        check("busy_after_align", busy_a, 1'b0);
        for (int k = 0; k < 4; k++) run_period(0, 40, 2, 40, 0);
        check("missed_steady", missed_a, 1'b0);
        check("ovf_steady", ovf_a, 1'b0);

        // Acknowledge coincident with the next edge
        run_period(0, 40, -1, 40, 0);
        run_period(0, 40, 2, 40, 1);
        check("missed_coinc", missed_a, 1'b0);

        // Edge while still busy
        run_period(0, 25, -1, 40, 0);
        run_period(0, 40, 2, 25, 0);
        check("missed_set", missed_a, 1'b1);
        run_period(0, 40, 2, 40, 0);
        check("missed_sticky", missed_a, 1'b1);

        // Reset in the middle of the handshake
        run_period(0, 40, -1, 40, 0);
        check("busy_before_rst", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_val", val_a, 20'h0);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_missed", missed_a, 1'b0);
        check("midrst_trig", trig_a, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        run_period(0, 40, -1, -1, 0);
        run_period(0, 40, 2, 40, 0);

        // Saturation on the 4-bit instance
        run_period(1, 30, -1, -1, 0);
        run_period(1, 30, 2, 15, 0);
        check("ovf_w4_set", ovf_b, 1'b1);
        run_period(1, 10, 2, 15, 0);
        run_period(1, 30, 2, 10, 0);
        check("ovf_w4_sticky", ovf_b, 1'b1);
        check("ovf_w20_clear", ovf_a, 1'b0);

        tick(5);
        check("queue_a_drained", exp_a.size(), 0);
        check("queue_b_drained", exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
